// File: rtl/fp_mul_ctrl_pkg.sv
// Shared constants and operand record for the shared FP multiplier controller.
package fp_mul_ctrl_pkg;

    localparam int FP_W = 32;
    localparam logic [7:0] EXP_MAX = 8'hFF;
    localparam logic [21:0] CFG_RESET = 22'b111;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } fp_pair_t;

    function automatic logic has_exc(input fp_pair_t op);
        return (op.a[30:23] == EXP_MAX) || (op.b[30:23] == EXP_MAX);
    endfunction

endpackage

// File: rtl/floating_point_mul.sv
// Combinational approximate single-precision multiplier; set cfg bits drop
// the matching low fraction bits of both operands before multiplying.
module floating_point_mul
    import fp_mul_ctrl_pkg::*;
#(
    parameter int CFG_W = 22
) (
    input  logic [FP_W-1:0]  a,
    input  logic [FP_W-1:0]  b,
    input  logic [CFG_W-1:0] cfg,
    output logic [FP_W-1:0]  result
);

    logic        sign;
    logic [22:0] mask;
    logic [22:0] fa;
    logic [22:0] fb;
    logic [47:0] prod;
    logic [47:0] pn;
    logic [9:0]  e_sum;
    logic [9:0]  e_res;
    logic        a_nan;
    logic        b_nan;
    logic        unused_lo;

    assign mask = 23'(cfg);
    assign a_nan = (a[30:23] == EXP_MAX) && (a[22:0] != '0);
    assign b_nan = (b[30:23] == EXP_MAX) && (b[22:0] != '0);
    assign unused_lo = ^{pn[47], pn[23:0]};

    always_comb begin
        sign = a[31] ^ b[31];
        fa = a[22:0] & ~mask;
        fb = b[22:0] & ~mask;
        prod = {24'b0, 1'b1, fa} * {24'b0, 1'b1, fb};
        pn = prod[47] ? prod : {prod[46:0], 1'b0};
        e_sum = {2'b0, a[30:23]} + {2'b0, b[30:23]} + {9'b0, prod[47]};
        e_res = e_sum - 10'd127;
        result = {sign, e_res[7:0], pn[46:24]};
        if ((a[30:23] == EXP_MAX) || (b[30:23] == EXP_MAX)) begin
            if (a_nan || b_nan)
                result = 32'h7FC0_0000;
            else
                result = {sign, EXP_MAX, 23'b0};
        end else if ((a[30:23] == 8'h00) || (b[30:23] == 8'h00)) begin
            result = {sign, 31'b0};
        end else if (e_sum <= 10'd127) begin
            result = {sign, 31'b0};
        end else if ((e_res[9:8] != 2'b00) || (e_res[7:0] == EXP_MAX)) begin
            result = {sign, EXP_MAX, 23'b0};
        end
    end

endmodule

// File: rtl/fp_mul_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches req upward from prio, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] prio,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(prio) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fp_mul_share_ctrl.sv
// Shares one floating_point_mul between NREQ requesters through a
// round-robin grant, a per-requester config bank and a 2-stage pipeline.
module fp_mul_share_ctrl
    import fp_mul_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CFG_W = 22,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    input  logic                 cfg_we,
    input  logic [ID_W-1:0]      cfg_id,
    input  logic [CFG_W-1:0]     cfg_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [FP_W-1:0]      rsp_result,
    output logic                 rsp_exc,
    output logic                 busy
);

    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
        logic [CFG_W-1:0] cfg;
        fp_pair_t         op;
    } stage_t;

    logic [CFG_W-1:0] cfg_q [NREQ];
    stage_t           s1;
    fp_pair_t         sel_op;
    logic [ID_W-1:0]  prio;
    logic [ID_W-1:0]  gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic [FP_W-1:0]  mul_res;
    logic             s1_en;
    logic             s2_en;
    logic             hs;

    assign s2_en = !rsp_valid || rsp_ready;
    assign s1_en = !s1.valid || s2_en;
    assign hs = s1_en && (|req_valid);
    assign req_ready = s1_en ? gnt : '0;
    assign busy = s1.valid || rsp_valid;
    assign sel_op.a = req_a[gnt_idx*FP_W +: FP_W];
    assign sel_op.b = req_b[gnt_idx*FP_W +: FP_W];

    rr_arbiter #(
        .NREQ(NREQ),
        .ID_W(ID_W)
    ) u_arb (
        .req(req_valid),
        .prio(prio),
        .gnt(gnt),
        .gnt_idx(gnt_idx)
    );

    floating_point_mul #(
        .CFG_W(CFG_W)
    ) u_mul (
        .a(s1.op.a),
        .b(s1.op.b),
        .cfg(s1.cfg),
        .result(mul_res)
    );

    // A same-cycle write lands after the grant reads the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++)
                cfg_q[i] <= CFG_W'(CFG_RESET);
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (cfg_we && (cfg_id == ID_W'(i)))
                    cfg_q[i] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            prio <= '0;
        end else begin
            if (s1_en) begin
                s1.valid <= hs;
                if (hs) begin
                    s1.id <= gnt_idx;
                    s1.cfg <= cfg_q[gnt_idx];
                    s1.op <= sel_op;
                end
            end
            if (hs)
                prio <= (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id <= '0;
            rsp_result <= '0;
            rsp_exc <= 1'b0;
        end else if (s2_en) begin
            rsp_valid <= s1.valid;
            rsp_id <= s1.id;
            rsp_result <= mul_res;
            rsp_exc <= has_exc(s1.op);
        end
    end

endmodule
